// File: rtl/band_scale_mc.sv
// Multi-band gain stage: one shared multiplier walks the bands of a frame,
// with per-band gain ramping, saturation and sticky clip flags.
`timescale 1ns/1ps
module band_scale_mc #(
  parameter int NUM_BANDS  = 4,
  parameter int DATA_W     = 16,
  parameter int POT_W      = 12,
  parameter int GAIN_SHIFT = 10,
  parameter int GAIN_MODE  = 1,
  parameter int RAMP_STEP  = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_BANDS*DATA_W-1:0] in_data,
  input  logic [NUM_BANDS*POT_W-1:0]  pot,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_BANDS*DATA_W-1:0] out_data,
  output logic [NUM_BANDS-1:0]        clip,
  input  logic                        clip_clr
);

  localparam int KW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int PW = DATA_W + POT_W + 1;
  localparam logic [KW-1:0] LAST = KW'(NUM_BANDS - 1);
  localparam logic signed [PW-1:0] MAXV = PW'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [PW-1:0] MINV = ~MAXV;
  localparam logic [POT_W-1:0] STEP = POT_W'(RAMP_STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_samp [NUM_BANDS];
  logic [POT_W-1:0]  r_pot  [NUM_BANDS];
  logic [POT_W-1:0]  r_gcur [NUM_BANDS];
  logic [DATA_W-1:0] r_out  [NUM_BANDS];
  logic [KW-1:0]     r_k;
  logic [KW-1:0]     r_pk;
  logic              r_pv;
  logic signed [PW-1:0] r_prod;
  logic [NUM_BANDS-1:0] r_clip;

  logic                     w_accept;
  logic signed [DATA_W-1:0] w_samp;
  logic [POT_W-1:0]         w_pot;
  logic [POT_W-1:0]         w_cur;
  logic [2*POT_W-1:0]       w_sq;
  logic [POT_W-1:0]         w_tgt;
  logic                     w_up;
  logic [POT_W-1:0]         w_mag;
  logic [POT_W-1:0]         w_dlt;
  logic [POT_W-1:0]         w_gnew;
  logic signed [PW-1:0]     w_prod;
  logic signed [PW-1:0]     w_res;
  logic                     w_hi;
  logic                     w_lo;
  logic [DATA_W-1:0]        w_wr;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_accept  = in_valid & in_ready;
  assign clip      = r_clip;

  for (genvar g = 0; g < NUM_BANDS; g++) begin : g_pack
    assign out_data[g*DATA_W +: DATA_W] = r_out[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (r_k == LAST) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Issue stage: gain update for band r_k and its product
  always_comb begin
    w_samp = r_samp[r_k];
    w_pot  = r_pot[r_k];
    w_cur  = r_gcur[r_k];
    w_sq   = w_pot * w_pot;
    w_tgt  = (GAIN_MODE != 0) ? POT_W'(w_sq >> POT_W) : w_pot;
    w_up   = (w_tgt >= w_cur);
    w_mag  = w_up ? (w_tgt - w_cur) : (w_cur - w_tgt);
    w_dlt  = (w_mag > STEP) ? STEP : w_mag;
    if (RAMP_STEP == 0) w_gnew = w_tgt;
    else w_gnew = w_up ? (w_cur + w_dlt) : (w_cur - w_dlt);
    w_prod = w_samp * $signed({1'b0, w_gnew});
  end

  // Write stage: shift, saturate, flag
  always_comb begin
    w_res = r_prod >>> GAIN_SHIFT;
    w_hi  = (w_res > MAXV);
    w_lo  = (w_res < MINV);
    w_wr  = w_res[DATA_W-1:0];
    if (w_hi) w_wr = {1'b0, {(DATA_W-1){1'b1}}};
    if (w_lo) w_wr = {1'b1, {(DATA_W-1){1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k    <= '0;
      r_pk   <= '0;
      r_pv   <= 1'b0;
      r_prod <= '0;
      r_clip <= '0;
      for (int k = 0; k < NUM_BANDS; k++) begin
        r_samp[k] <= '0;
        r_pot[k]  <= '0;
        r_gcur[k] <= '0;
        r_out[k]  <= '0;
      end
    end else begin
      if (w_accept) begin
        for (int k = 0; k < NUM_BANDS; k++) begin
          r_samp[k] <= in_data[k*DATA_W +: DATA_W];
          r_pot[k]  <= pot[k*POT_W +: POT_W];
        end
      end
      if (w_accept) r_k <= '0;
      else if (r_state == S_RUN) r_k <= r_k + 1'b1;
      r_pv <= (r_state == S_RUN);
      if (r_state == S_RUN) begin
        r_prod     <= w_prod;
        r_pk       <= r_k;
        r_gcur[r_k] <= w_gnew;
      end
      if (r_pv) r_out[r_pk] <= w_wr;
      // a fresh saturation beats a same-cycle clear
      if (clip_clr) r_clip <= '0;
      if (r_pv && (w_hi || w_lo)) r_clip[r_pk] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_band_scale_mc.sv
// Directed bench for band_scale_mc: square-law/no-ramp instance (a)
// and linear/ramped instance (b) sharing one clock.
`timescale 1ns/1ps
module tb_band_scale_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        a_rst_n, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_clr;
  logic [63:0] a_in_data, a_out_data;
  logic [47:0] a_pot;
  logic [3:0]  a_clip;

  logic        b_rst_n, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_clr;
  logic [63:0] b_in_data, b_out_data;
  logic [47:0] b_pot;
  logic [3:0]  b_clip;

  band_scale_mc #(
    .NUM_BANDS(4), .DATA_W(16), .POT_W(12),
    .GAIN_SHIFT(10), .GAIN_MODE(1), .RAMP_STEP(0)
  ) dut_a (
    .clk(clk), .rst_n(a_rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .pot(a_pot),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .clip(a_clip), .clip_clr(a_clr)
  );

  band_scale_mc #(
    .NUM_BANDS(4), .DATA_W(16), .POT_W(12),
    .GAIN_SHIFT(10), .GAIN_MODE(0), .RAMP_STEP(64)
  ) dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .pot(b_pot),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .clip(b_clip), .clip_clr(b_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // lat counts rising edges from the accept edge (counted as 1)
  task automatic send_a(input logic [63:0] d, input logic [47:0] p,
                        output int lat);
    @(negedge clk);
    a_in_data = d; a_pot = p; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 1;
    while (!a_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic send_b(input logic [63:0] d, input logic [47:0] p,
                        output int lat);
    @(negedge clk);
    b_in_data = d; b_pot = p; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic ack_a();
    @(negedge clk) a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  task automatic ack_b();
    @(negedge clk) b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    int rexp[6];
    logic [63:0] frame1;
    rexp = '{64, 128, 192, 256, 256, 192};
    frame1 = {16'h0000, 16'h8000, 16'h7FFF, 16'h03FF};

    a_rst_n = 0; a_in_valid = 0; a_out_ready = 0; a_clr = 0;
    a_in_data = '0; a_pot = '0;
    b_rst_n = 0; b_in_valid = 0; b_out_ready = 0; b_clr = 0;
    b_in_data = '0; b_pot = '0;
    repeat (3) @(negedge clk);

    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_clip", a_clip, 0);
    chk("rst_b_out_data", b_out_data, 0);
    a_rst_n = 1; b_rst_n = 1;

    // full-scale square-law gain 4094, saturation both ways
    send_a({16'h0000, 16'h8000, 16'h7FFF, 16'h0100}, {4{12'hFFF}}, lat);
    chk("latency", lat, 6);
    chk("out_valid", a_out_valid, 1);
    chk("band0", a_out_data[15:0], 16'h03FF);
    chk("frame1", a_out_data, frame1);
    chk("clip_sat", a_clip, 4'b0110);
    chk("in_ready_done", a_in_ready, 0);

    // backpressure: hold DONE, poke in_valid
    repeat (5) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_data = 64'h1111_2222_3333_4444;
      a_pot = {4{12'h123}};
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      chk("hold_valid", a_out_valid, 1);
      chk("hold_data", a_out_data, frame1);
      chk("hold_clip", a_clip, 4'b0110);
      chk("hold_in_ready", a_in_ready, 0);
    end
    ack_a();
    chk("idle_in_ready", a_in_ready, 1);
    chk("idle_out_valid", a_out_valid, 0);
    chk("data_kept", a_out_data, frame1);

    @(negedge clk) a_clr = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0;
    chk("clip_clr", a_clip, 0);

    // clear collides with band1 saturation write (edge 3 after accept)
    @(negedge clk);
    a_in_data = {16'h0000, 16'h0000, 16'h7FFF, 16'h0000};
    a_pot = {4{12'hFFF}};
    a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    a_clr = 1'b1;
    @(posedge clk); #1;
    a_clr = 1'b0;
    lat = 4;
    while (!a_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency2", lat, 6);
    chk("clip_set_wins", a_clip, 4'b0010);
    chk("frame2", a_out_data, {16'h0000, 16'h0000, 16'h7FFF, 16'h0000});
    ack_a();

    // g=256: -1024 -> -256, -1 -> -1 (floor)
    send_a({16'h0000, 16'h0000, 16'hFFFF, 16'hFC00}, {4{12'h400}}, lat);
    chk("latency3", lat, 6);
    chk("neg_floor", a_out_data, 64'h0000_0000_FFFF_FF00);
    chk("clip_sticky", a_clip, 4'b0010);
    ack_a();

    // linear, ramp 64 toward 256 then back toward 0
    for (int i = 0; i < 6; i++) begin
      send_b({4{16'd1024}}, (i < 5) ? {4{12'd256}} : 48'd0, lat);
      chk("ramp_lat", lat, 6);
      chk("ramp_out", b_out_data, {4{16'(rexp[i])}});
      ack_b();
    end
    chk("ramp_clip", b_clip, 0);

    // reset two cycles into RUN
    @(negedge clk);
    b_in_data = {4{16'd1024}}; b_pot = {4{12'd256}}; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    b_rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_in_ready", b_in_ready, 1);
    chk("mid_rst_out_valid", b_out_valid, 0);
    chk("mid_rst_out_data", b_out_data, 0);
    chk("mid_rst_clip", b_clip, 0);
    @(negedge clk) b_rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (b_out_valid) seen = 1;
    end
    chk("no_partial_frame", seen, 0);
    send_b({4{16'd1024}}, {4{12'd256}}, lat);
    chk("post_rst_lat", lat, 6);
    chk("post_rst_ramp", b_out_data, {4{16'd64}});
    ack_b();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
